// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: I/O register offsets,
// status bit positions and the prescaler width helper.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IO_GPIO_OUT = 2'd0,
    IO_GPIO_IN  = 2'd1,
    IO_TIMER    = 2'd2,
    IO_STATUS   = 2'd3
  } io_reg_e;

  localparam int unsigned IO_REGS = 4;

  localparam int unsigned ST_OVF  = 0;
  localparam int unsigned ST_CHG  = 1;
  localparam int unsigned ST_BITS = 2;

  // A prescale of 1 still needs a one-bit counter that simply stays at 0.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core (master) and the memory responder (slave).
interface data_mem_responder_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 8,
  parameter int unsigned MEM_DATA_WIDTH = 8
);

  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata;
  logic                      mem_WE;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_WE,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_WE,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_responder_io_timer.sv
// Prescaled free-running timer with a load port; o_ovf flags the increment
// that wraps the count from all-ones to zero.
module data_mem_responder_io_timer
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf
);

  localparam int unsigned       PS_W    = prescale_width(PRESCALE);
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  r_prescale;
  logic [WIDTH-1:0] r_count;
  logic             w_tick;

  assign w_tick = (r_prescale == PS_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_prescale <= '0;
      r_count    <= '0;
    end else if (i_load) begin
      r_prescale <= '0;
      r_count    <= i_load_data;
    end else if (w_tick) begin
      r_prescale <= '0;
      r_count    <= r_count + 1'b1;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // A load replaces the increment, so it can never report an overflow.
  assign o_ovf   = w_tick && !i_load && (r_count == '1);
  assign o_count = r_count;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: RAM below IO_BASE, and GPIO/timer/status registers
// in a four-word I/O window. Reads are combinational, writes take effect at the edge.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 8,
  parameter int unsigned MEM_DATA_WIDTH = 8,
  parameter int unsigned PRESCALE       = 4,
  parameter int unsigned IO_BASE        = 'hFC
) (
  input  logic                      clk,
  input  logic                      arst,
  data_mem_responder_if.slave       mem,
  input  logic [MEM_DATA_WIDTH-1:0] gpio_i,
  output logic [MEM_DATA_WIDTH-1:0] gpio_o,
  output logic                      irq
);

  localparam logic [MEM_ADDR_WIDTH-1:0] IO_BASE_A = MEM_ADDR_WIDTH'(IO_BASE);

  logic [MEM_DATA_WIDTH-1:0] r_ram [IO_BASE];
  logic [MEM_DATA_WIDTH-1:0] r_gpio_o;
  logic [MEM_DATA_WIDTH-1:0] r_sync1;
  logic [MEM_DATA_WIDTH-1:0] r_sync2;
  logic [MEM_DATA_WIDTH-1:0] r_sync3;
  logic [ST_BITS-1:0]        r_status;

  logic                      w_is_io;
  logic [MEM_ADDR_WIDTH-1:0] w_io_off;
  logic                      w_io_valid;
  io_reg_e                   w_io_sel;
  logic                      w_wr_ram;
  logic                      w_wr_gpio;
  logic                      w_wr_timer;
  logic                      w_wr_status;
  logic                      w_chg;
  logic                      w_ovf;
  logic [MEM_DATA_WIDTH-1:0] w_timer;
  logic [ST_BITS-1:0]        w_set;
  logic [ST_BITS-1:0]        w_clr;
  logic [MEM_DATA_WIDTH-1:0] w_rdata;

  // Address decode
  assign w_is_io    = (mem.mem_addr >= IO_BASE_A);
  assign w_io_off   = mem.mem_addr - IO_BASE_A;
  assign w_io_valid = w_is_io && (w_io_off < MEM_ADDR_WIDTH'(IO_REGS));
  assign w_io_sel   = io_reg_e'(w_io_off[1:0]);

  assign w_wr_ram    = mem.mem_WE && !w_is_io;
  assign w_wr_gpio   = mem.mem_WE && w_io_valid && (w_io_sel == IO_GPIO_OUT);
  assign w_wr_timer  = mem.mem_WE && w_io_valid && (w_io_sel == IO_TIMER);
  assign w_wr_status = mem.mem_WE && w_io_valid && (w_io_sel == IO_STATUS);

  // NOTE: the RAM array has no reset branch; clearing a memory in reset turns
  // it into a wide bank of flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram[mem.mem_addr] <= mem.mem_wdata;
    end
  end

  data_mem_responder_io_timer #(
    .WIDTH    (MEM_DATA_WIDTH),
    .PRESCALE (PRESCALE)
  ) u_io_timer (
    .clk         (clk),
    .arst        (arst),
    .i_load      (w_wr_timer),
    .i_load_data (mem.mem_wdata),
    .o_count     (w_timer),
    .o_ovf       (w_ovf)
  );

  // Stage 3 only remembers the previous synchronised sample for edge detection.
  assign w_chg = (r_sync2 != r_sync3);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_set         = '0;
    w_set[ST_OVF] = w_ovf;
    w_set[ST_CHG] = w_chg;
    w_clr         = w_wr_status ? mem.mem_wdata[ST_BITS-1:0] : '0;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_gpio_o <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
      r_status <= '0;
    end else begin
      r_sync1  <= gpio_i;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      if (w_wr_gpio) begin
        r_gpio_o <= mem.mem_wdata;
      end
      // A set event in the same cycle as write-1-to-clear keeps the bit set.
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (!w_is_io) begin
      w_rdata = r_ram[mem.mem_addr];
    end else if (w_io_valid) begin
      unique case (w_io_sel)
        IO_GPIO_OUT: w_rdata = r_gpio_o;
        IO_GPIO_IN:  w_rdata = r_sync2;
        IO_TIMER:    w_rdata = w_timer;
        IO_STATUS:   w_rdata = MEM_DATA_WIDTH'(r_status);
        default:     w_rdata = '0;
      endcase
    end
  end

  assign mem.mem_rdata = w_rdata;
  assign gpio_o        = r_gpio_o;
  assign irq           = |r_status;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations are queued as stimulus
// is driven and popped when the corresponding output is sampled.
module tb_data_mem_responder;

  localparam logic [7:0] A_GPIO_OUT = 8'hFC;
  localparam logic [7:0] A_GPIO_IN  = 8'hFD;
  localparam logic [7:0] A_TIMER    = 8'hFE;
  localparam logic [7:0] A_STATUS   = 8'hFF;

  typedef enum {K_RD, K_GPO, K_IRQ} kind_e;
  typedef struct {
    string      tag;
    kind_e      kind;
    logic [7:0] exp;
  } exp_t;

  logic       clk;
  logic       arst;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o;
  logic       irq;

  int   n_total;
  int   n_bad;
  exp_t sb[$];

  data_mem_responder_if bus ();

  data_mem_responder dut (
    .clk    (clk),
    .arst   (arst),
    .mem    (bus),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%02h want=%02h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input kind_e kind, input logic [7:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic collect();
    exp_t       e;
    logic [7:0] got;
    if (sb.size() == 0) begin
      check("sb_underflow", 8'h01, 8'h00);
      return;
    end
    e = sb.pop_front();
    case (e.kind)
      K_RD:    got = bus.mem_rdata;
      K_GPO:   got = gpio_o;
      default: got = {7'b0, irq};
    endcase
    check(e.tag, got, e.exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_WE    = 1'b1;
    step();
    bus.mem_WE    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus.mem_addr = addr;
    expect_val(tag, K_RD, exp);
    #1;
    collect();
  endtask

  task automatic obs(input string tag, input kind_e kind, input logic [7:0] exp);
    expect_val(tag, kind, exp);
    #1;
    collect();
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    arst          = 1'b1;
    gpio_i        = 8'h00;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    bus.mem_WE    = 1'b0;

    // Reset state
    #1 arst = 1'b0;
    #1;
    obs("rst_gpio_o", K_GPO, 8'h00);
    obs("rst_irq",    K_IRQ, 8'h00);
    rd("rst_timer",  A_TIMER,   8'h00);
    rd("rst_status", A_STATUS,  8'h00);
    rd("rst_gpin",   A_GPIO_IN, 8'h00);
    step();
    arst = 1'b1;

    // RAM write/read
    wr(8'h11, 8'h77);
    wr(8'h10, 8'h5A);
    rd("ram_10", 8'h10, 8'h5A);
    rd("ram_11", 8'h11, 8'h77);

    // Read-during-write returns the old value, new value next cycle
    bus.mem_addr  = 8'h10;
    bus.mem_wdata = 8'hA5;
    bus.mem_WE    = 1'b1;
    expect_val("rdw_old", K_RD, 8'h5A);
    #1;
    collect();
    step();
    bus.mem_WE = 1'b0;
    rd("rdw_new", 8'h10, 8'hA5);
    rd("rdw_neighbour", 8'h11, 8'h77);

    // GPIO out, synchroniser latency, CHG, write-1-to-clear
    wr(A_GPIO_OUT, 8'h3C);
    obs("gpo_pin", K_GPO, 8'h3C);
    rd("gpo_rd", A_GPIO_OUT, 8'h3C);
    gpio_i = 8'h81;
    step();
    rd("gpin_1clk", A_GPIO_IN, 8'h00);
    step();
    rd("gpin_2clk", A_GPIO_IN, 8'h81);
    rd("chg_2clk",  A_STATUS,  8'h00);
    obs("irq_2clk", K_IRQ, 8'h00);
    step();
    rd("chg_3clk",  A_STATUS,  8'h02);
    obs("irq_3clk", K_IRQ, 8'h01);
    wr(A_STATUS, 8'h02);
    rd("chg_clr",     A_STATUS, 8'h00);
    obs("irq_chg_clr", K_IRQ, 8'h00);
    wr(A_GPIO_IN, 8'h55);
    rd("gpin_ro", A_GPIO_IN, 8'h81);

    // Timer: load, prescaled increments, overflow
    wr(A_TIMER, 8'hFE);
    rd("tmr_load", A_TIMER, 8'hFE);
    steps(3);
    rd("tmr_w3", A_TIMER, 8'hFE);
    step();
    rd("tmr_w4", A_TIMER, 8'hFF);
    steps(3);
    rd("tmr_w7",     A_TIMER,  8'hFF);
    rd("ovf_before", A_STATUS, 8'h00);
    step();
    rd("tmr_w8",  A_TIMER,  8'h00);
    rd("ovf_set", A_STATUS, 8'h01);
    obs("irq_ovf", K_IRQ, 8'h01);

    // Timer write beats the same-cycle FF->00 increment; no OVF raised
    wr(A_TIMER, 8'hFF);
    wr(A_STATUS, 8'h01);
    rd("ovf_clr", A_STATUS, 8'h00);
    steps(2);
    wr(A_TIMER, 8'h05);
    rd("tmr_wr_win",  A_TIMER,  8'h05);
    rd("tmr_wr_novf", A_STATUS, 8'h00);
    obs("irq_wr_novf", K_IRQ, 8'h00);
    steps(3);
    rd("tmr_ps_clr3", A_TIMER, 8'h05);
    step();
    rd("tmr_ps_clr4", A_TIMER, 8'h06);

    // STATUS clear collides with an overflow: OVF stays set
    wr(A_TIMER, 8'hFF);
    steps(3);
    wr(A_STATUS, 8'h01);
    rd("coll_tmr",    A_TIMER,  8'h00);
    rd("coll_status", A_STATUS, 8'h01);
    obs("coll_irq", K_IRQ, 8'h01);

    // Asynchronous reset between edges while the timer runs
    steps(2);
    arst   = 1'b0;
    gpio_i = 8'h00;
    obs("arst_gpio_o", K_GPO, 8'h00);
    obs("arst_irq",    K_IRQ, 8'h00);
    rd("arst_timer",  A_TIMER,   8'h00);
    rd("arst_status", A_STATUS,  8'h00);
    rd("arst_gpin",   A_GPIO_IN, 8'h00);
    steps(2);
    rd("arst_hold", A_TIMER, 8'h00);
    arst = 1'b1;
    steps(3);
    rd("rel_tmr3", A_TIMER, 8'h00);
    step();
    rd("rel_tmr4",   A_TIMER,  8'h01);
    rd("rel_status", A_STATUS, 8'h00);
    obs("rel_gpio_o", K_GPO, 8'h00);

    if (sb.size() != 0) check("sb_leftover", 8'(sb.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
